vc_output_arbiter: RTL
======================

// Module: vc_output_arbiter
// PURPOSE
//  Output side of the VC buffer plane: the read-side counterpart of the VC input demux.
//  Round-robin arbitrates among VC FIFOs holding a head flit, locks the winner for the
//  whole packet (head..tail), pops its flits and drives one registered valid/ready output.
//  Sits between the per-port VC FIFOs and the crossbar/output link.
// PARAMETERS
//  VC          4   number of virtual channels (FIFOs) on this port
//  DATA_WIDTH  32  flit width; bits [DATA_WIDTH-1:DATA_WIDTH-2] carry flit type
// PORTS
//  clk            in   1               single clock, rising edge
//  rst_n          in   1               asynchronous, active-low reset
//  doutVC         in   VC*DATA_WIDTH   FWFT front flit of each VC FIFO, VC i at [i*DW +: DW]
//  emptyVC        in   VC              per-VC FIFO empty
//  rd_enVC        out  VC              per-VC pop, one-hot or zero
//  data_out       out  DATA_WIDTH      flit to downstream
//  valid_out      out  1               data_out holds a flit
//  ready_in       in   1               downstream accepts when valid_out & ready_in
//  VCPlaneSelector out $clog2(VC)      VC currently granted (VC of flit in data_out)
//  busy           out  1               FSM in LOCKED
//  err_proto      out  1               sticky: non-head flit at front of a requesting VC in IDLE
// BEHAVIOUR
//  Reset: rd_enVC=0, data_out=0, valid_out=0, VCPlaneSelector=0, busy=0, err_proto=0,
//   rr pointer=0, FSM=IDLE. Reset mid-packet discards held flit; no pop on release cycle.
//  FIFOs are first-word-fall-through: doutVC slice valid while !emptyVC[i]; rd_en pops.
//  Flit type: 01 HEAD, 00 BODY, 10 TAIL, 11 SINGLE (head+tail).
//  req[i] = !emptyVC[i] & type(doutVC[i]) in {HEAD,SINGLE}.
//  !emptyVC[i] with BODY/TAIL front in IDLE: not a request, sets err_proto (sticky till reset).
//  FSM IDLE: if any req, pick first set req at/after rr pointer (wrapping VC-1 -> 0);
//   register grant into VCPlaneSelector, go LOCKED. No pop in arbitration cycle.
//  FSM LOCKED: slot_free = !valid_out | ready_in.
//   pop = slot_free & !emptyVC[grant]; rd_enVC = pop << grant (combinational).
//   On pop: data_out <= doutVC[grant], valid_out <= 1 next cycle.
//   If slot_free & !pop: valid_out <= 0 (granted VC starved; grant held, bubbles allowed).
//   Popped flit TAIL or SINGLE: go IDLE, rr pointer <= grant+1 mod VC.
//  In IDLE with valid_out=1 (last tail pending): valid_out clears on ready_in; new
//   arbitration proceeds in parallel; data_out/valid_out held stable while !ready_in.
//  Latency: head at FIFO front in IDLE -> valid_out 2 cycles later (arb, pop/load).
//  Throughput: 1 flit/cycle within packet while ready_in=1 and FIFO non-empty.
//  Backpressure: ready_in=0 with valid_out=1 -> no pop, outputs held unchanged.
//  Never pops more than one VC per cycle; never pops in IDLE; never pops on empty VC.
//  Non-granted VCs are never popped even if they hold HEADs (no packet interleave).
// STRUCTURE
//  Shared package noc_pkg: FLIT_TYPE_W=2, FLIT_HEAD/BODY/TAIL/SINGLE constants,
//   flit_type() extract function, FSM state typedef {IDLE, LOCKED}.
//  Sub-module rr_arbiter #(N): req[N], ptr[$clog2(N)] -> grant index + any_grant,
//   purely combinational; pointer register lives in vc_output_arbiter.
//  Remaining RTL: FSM, grant/pointer regs, output register, pop logic, err flag.
// TESTING
//  1 Reset: rst_n low mid-packet (VC1 locked, valid_out=1) -> all outputs 0 next
//    edge-independent, FSM IDLE, pointer 0; after release no rd_enVC for 1 cycle.
//  2 Single packet: VC2 holds HEAD,BODY,TAIL, ready_in=1 -> VCPlaneSelector=2 at t+1,
//    rd_enVC=4'b0100 t+1..t+3, valid_out t+2..t+4 with flits in order, then IDLE.
//  3 Round robin: all 4 VCs hold SINGLE flits, ready_in=1 -> grant order 0,1,2,3,0;
//    after 2-flit packet on VC3 pointer=0.
//  4 Backpressure: VC0 3-flit packet, ready_in=0 for 3 cycles after first valid ->
//    data_out stable, rd_enVC=0 during stall, no flit lost or duplicated.
//  5 Starvation: VC1 HEAD then empty 4 cycles, VC3 HEAD waiting -> grant stays 1,
//    valid_out drops, rd_enVC[3] never asserted until VC1 TAIL popped.
//  6 Protocol error: VC0 front = BODY in IDLE -> err_proto=1 sticky, VC0 not granted,
//    VC2 HEAD still served normally.

Source files
------------

// File: rtl/noc_pkg.sv
// Flit-type encoding and arbiter FSM encoding shared by the VC output arbiter
// and its round-robin sub-block.
package noc_pkg;

  localparam int FLIT_TYPE_W = 2;

  typedef enum logic [FLIT_TYPE_W-1:0] {
    FLIT_BODY   = 2'b00,
    FLIT_HEAD   = 2'b01,
    FLIT_TAIL   = 2'b10,
    FLIT_SINGLE = 2'b11
  } flit_type_t;

  typedef logic [0:0] arb_state_t;
  localparam arb_state_t ST_IDLE   = 1'b0;
  localparam arb_state_t ST_LOCKED = 1'b1;

  function automatic flit_type_t flit_type(input logic [FLIT_TYPE_W-1:0] type_bits);
    return flit_type_t'(type_bits);
  endfunction

  function automatic logic starts_packet(input flit_type_t t);
    return (t == FLIT_HEAD) || (t == FLIT_SINGLE);
  endfunction

  function automatic logic ends_packet(input flit_type_t t);
    return (t == FLIT_TAIL) || (t == FLIT_SINGLE);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr_i,
// wrapping from N-1 back to 0. The pointer register lives in the caller.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] grant_o,
  output logic          any_grant_o
);

  // Scan farthest-first so the closest request to the pointer is written last.
  always_comb begin
    grant_o     = '0;
    any_grant_o = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      logic [IW-1:0] idx;
      idx = IW'((int'(ptr_i) + k) % N);
      if (req_i[idx]) begin
        grant_o     = idx;
        any_grant_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vc_output_arbiter.sv
// Read side of the VC buffer plane: picks a VC holding a packet head, keeps it
// for the whole packet and streams its flits through one registered output.
module vc_output_arbiter
  import noc_pkg::*;
#(
  parameter int VC         = 4,
  parameter int DATA_WIDTH = 32,
  localparam int SEL_W     = (VC > 1) ? $clog2(VC) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [VC*DATA_WIDTH-1:0] doutVC,
  input  logic [VC-1:0]            emptyVC,
  output logic [VC-1:0]            rd_enVC,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     valid_out,
  input  logic                     ready_in,
  output logic [SEL_W-1:0]         VCPlaneSelector,
  output logic                     busy,
  output logic                     err_proto
);

  arb_state_t             state_q, state_d;
  logic [SEL_W-1:0]       grant_q, grant_d;
  logic [SEL_W-1:0]       ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;

  logic [VC-1:0]          req;
  logic [VC-1:0]          bad_front;
  logic [SEL_W-1:0]       arb_grant;
  logic                   arb_any;
  logic [DATA_WIDTH-1:0]  grant_flit;
  flit_type_t             grant_type;
  logic                   slot_free;
  logic                   pop;

  // A non-empty VC whose front flit cannot open a packet is a protocol error.
  always_comb begin
    req       = '0;
    bad_front = '0;
    for (int i = 0; i < VC; i++) begin
      if (!emptyVC[i]) begin
        if (starts_packet(flit_type(doutVC[i*DATA_WIDTH + DATA_WIDTH - 1 -: FLIT_TYPE_W])))
          req[i] = 1'b1;
        else
          bad_front[i] = 1'b1;
      end
    end
  end

  rr_arbiter #(.N(VC)) u_rr (
    .req_i      (req),
    .ptr_i      (ptr_q),
    .grant_o    (arb_grant),
    .any_grant_o(arb_any)
  );

  assign grant_flit = doutVC[grant_q*DATA_WIDTH +: DATA_WIDTH];
  assign grant_type = flit_type(grant_flit[DATA_WIDTH-1 -: FLIT_TYPE_W]);
  assign slot_free  = !valid_q || ready_in;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    valid_d = valid_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A pending tail drains while the next winner is chosen.
        if (valid_q && ready_in)
          valid_d = 1'b0;
        if (arb_any) begin
          grant_d = arb_grant;
          state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        pop = slot_free && !emptyVC[grant_q];
        if (pop) begin
          data_d  = grant_flit;
          valid_d = 1'b1;
          if (ends_packet(grant_type)) begin
            state_d = ST_IDLE;
            ptr_d   = (grant_q == SEL_W'(VC - 1)) ? '0 : grant_q + 1'b1;
          end
        end else if (slot_free) begin
          valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign err_d = err_q || ((state_q == ST_IDLE) && (|bad_front));

  always_comb begin
    rd_enVC = '0;
    for (int i = 0; i < VC; i++)
      rd_enVC[i] = pop && (grant_q == SEL_W'(i));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign data_out        = data_q;
  assign valid_out       = valid_q;
  assign VCPlaneSelector = grant_q;
  assign busy            = (state_q == ST_LOCKED);
  assign err_proto       = err_q;

endmodule
